eth_ipv4_tcp_dut: RTL and testbench

// - Byte-stream receive parser for a simplified Ethernet/IPv4/TCP frame on AXI-Stream.
// - Frame layout, 26-byte header, MSB first:
//   eth_dst[6], eth_src[6], ethertype[2], ip_src[4], ip_dst[4], tcp_src[2], tcp_dst[2], payload.
// - Validates and strips the header, publishes source addresses, and forwards the payload on m_axis.
// - Sits between the MAC RX stream and the TCP payload consumer.

---
 rtl/eth_ipv4_tcp_dut.sv | 173 +++++++++++++++++
 tb/tb_eth_ipv4_tcp_dut.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_ipv4_tcp_dut.sv
// Ethernet/IPv4/TCP receive parser: checks and strips the 26-byte header, publishes source fields, forwards payload.
// Optional macro ADDR_FILTER_EN: also require dst MAC (or broadcast), dst IP and dst TCP port to match.
`timescale 1ns/1ps
module eth_ipv4_tcp_dut #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_02,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
    parameter logic [15:0] LOCAL_PORT = 16'd443
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  hdr_valid,
    output logic [47:0]           hdr_eth_src,
    output logic [31:0]           hdr_ip_src,
    output logic [15:0]           hdr_src_port,
    output logic [15:0]           drop_cnt
);

    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

    state_t                  state;
    logic [4:0]              byte_cnt;
    logic                    bad;
    logic                    run;
    logic [47:0]             eth_src_sr;
    logic [31:0]             ip_src_sr;
    logic [15:0]             src_port_sr;
    logic [DATA_WIDTH-1:0]   pay_data_p1;
    logic                    pay_last_p1;
    logic                    vld_p1;
    logic                    beat;
    logic                    last_hdr_byte;
    logic                    etype_bad;
    logic                    addr_bad;
    logic                    bad_now;
    logic                    unused_tkeep;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign unused_tkeep  = s_axis_tkeep;
    // run holds ready low during and for one cycle after reset
    assign s_axis_tready = run && ((state != PAYLOAD) || !vld_p1 || m_axis_tready);
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign last_hdr_byte = (byte_cnt == 5'd25);

    assign m_axis_tdata  = pay_data_p1;
    assign m_axis_tlast  = pay_last_p1;
    assign m_axis_tvalid = vld_p1;
    assign m_axis_tkeep  = vld_p1;

    always_comb begin
        etype_bad = 1'b0;
        case (byte_cnt)
            5'd12:   etype_bad = (s_axis_tdata != 8'h08);
            5'd13:   etype_bad = (s_axis_tdata != 8'h00);
            default: etype_bad = 1'b0;
        endcase
    end

`ifdef ADDR_FILTER_EN
    logic [47:0] eth_dst_sr;
    logic [31:0] ip_dst_sr;
    logic [7:0]  tcp_dst_hi;

    always_ff @(posedge clk) begin
        if (state == HDR && beat) begin
            if (byte_cnt < 5'd6)
                eth_dst_sr <= {eth_dst_sr[39:0], s_axis_tdata};
            if (byte_cnt >= 5'd18 && byte_cnt <= 5'd21)
                ip_dst_sr <= {ip_dst_sr[23:0], s_axis_tdata};
            if (byte_cnt == 5'd24)
                tcp_dst_hi <= s_axis_tdata;
        end
    end

    // Evaluated only on byte 25, which supplies the low byte of the destination port
    assign addr_bad = ((eth_dst_sr != LOCAL_MAC) && (eth_dst_sr != 48'hFFFF_FFFF_FFFF))
                   || (ip_dst_sr != LOCAL_IP)
                   || ({tcp_dst_hi, s_axis_tdata} != LOCAL_PORT);
`else
    assign addr_bad = 1'b0;
`endif

    assign bad_now = bad || etype_bad || (last_hdr_byte && addr_bad);

    always_ff @(posedge clk) begin
        if (state == HDR && beat) begin
            if (byte_cnt >= 5'd6 && byte_cnt <= 5'd11)
                eth_src_sr <= {eth_src_sr[39:0], s_axis_tdata};
            if (byte_cnt >= 5'd14 && byte_cnt <= 5'd17)
                ip_src_sr <= {ip_src_sr[23:0], s_axis_tdata};
            if (byte_cnt == 5'd22 || byte_cnt == 5'd23)
                src_port_sr <= {src_port_sr[7:0], s_axis_tdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HDR;
            byte_cnt     <= 5'd0;
            bad          <= 1'b0;
            run          <= 1'b0;
            vld_p1       <= 1'b0;
            pay_data_p1  <= '0;
            pay_last_p1  <= 1'b0;
            hdr_valid    <= 1'b0;
            hdr_eth_src  <= 48'd0;
            hdr_ip_src   <= 32'd0;
            hdr_src_port <= 16'd0;
            drop_cnt     <= 16'd0;
        end else begin
            run       <= 1'b1;
            hdr_valid <= 1'b0;
            if (vld_p1 && m_axis_tready)
                vld_p1 <= 1'b0;
            case (state)
                HDR: begin
                    if (beat) begin
                        if (s_axis_tlast || last_hdr_byte) begin
                            byte_cnt <= 5'd0;
                            bad      <= 1'b0;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                            bad      <= bad_now;
                        end
                        if (last_hdr_byte && !bad_now) begin
                            hdr_valid    <= 1'b1;
                            hdr_eth_src  <= eth_src_sr;
                            hdr_ip_src   <= ip_src_sr;
                            hdr_src_port <= src_port_sr;
                            if (!s_axis_tlast)
                                state <= PAYLOAD;
                        end else if (s_axis_tlast) begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end else if (last_hdr_byte) begin
                            state <= DROP;
                        end
                    end
                end
                // ---- payload output register stage (p1) ----
                PAYLOAD: begin
                    if (beat) begin
                        vld_p1      <= 1'b1;
                        pay_data_p1 <= s_axis_tdata;
                        pay_last_p1 <= s_axis_tlast;
                        if (s_axis_tlast)
                            state <= HDR;
                    end
                end
                DROP: begin
                    if (beat && s_axis_tlast) begin
                        drop_cnt <= sat_inc(drop_cnt);
                        state    <= HDR;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_ipv4_tcp_dut.sv
// Directed scoreboard bench for eth_ipv4_tcp_dut: frames built in the bench, payload expectations queued and popped on m_axis.
`timescale 1ns/1ps
module tb_eth_ipv4_tcp_dut;

`ifdef ADDR_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif
    localparam logic [47:0] LMAC    = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01;
    localparam logic [31:0] LIP     = 32'hC0A80002;
    localparam logic [31:0] SIP     = 32'hC0A80001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_keep = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_keep, m_valid, m_last;
    logic        m_ready = 1'b1;
    logic        hdr_valid;
    logic [47:0] hdr_eth_src;
    logic [31:0] hdr_ip_src;
    logic [15:0] hdr_src_port;
    logic [15:0] drop_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          hv_cnt = 0;
    int          stall_cnt = 0;
    logic        tog_en = 1'b0;
    logic [8:0]  sb[$];
    logic [7:0]  fb[$];

    int          exp_hv = 0;
    logic [15:0] exp_drop = 16'd0;
    logic [15:0] exp_sport = 16'd0;
    logic [31:0] exp_sip = 32'd0;
    logic [47:0] exp_smac = 48'd0;

    eth_ipv4_tcp_dut dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .hdr_valid     (hdr_valid),
        .hdr_eth_src   (hdr_eth_src),
        .hdr_ip_src    (hdr_ip_src),
        .hdr_src_port  (hdr_src_port),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Downstream ready: steady high, or toggling every cycle for the backpressure frame
    always @(posedge clk) begin
        #1;
        if (tog_en) m_ready = ~m_ready;
        else        m_ready = 1'b1;
    end

    // Output monitor: a beat with valid && ready at the negedge transfers on the next posedge
    always @(negedge clk) begin
        if (!rst) begin
            if (hdr_valid) hv_cnt++;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 64'(m_valid), 64'(1'b0));
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("payload", 64'({m_last, m_data}), 64'(e));
                    chk("tkeep", 64'(m_keep), 64'(1'b1));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat has been accepted
    task automatic send_beat(input logic [7:0] d, input logic l);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 1000) begin
            t++;
            stall_cnt++;
            @(negedge clk);
        end
        if (t >= 1000) chk("s_ready_timeout", 64'(s_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] et, input logic [31:0] sip,
                         input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp,
                         input int plen, input logic [7:0] seed);
        logic [47:0] smac;
        smac = SRC_MAC;
        fb.delete();
        for (int i = 5; i >= 0; i--) fb.push_back(dmac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(smac[i*8 +: 8]);
        fb.push_back(et[15:8]);  fb.push_back(et[7:0]);
        for (int i = 3; i >= 0; i--) fb.push_back(sip[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) fb.push_back(dip[i*8 +: 8]);
        fb.push_back(sp[15:8]);  fb.push_back(sp[7:0]);
        fb.push_back(dp[15:8]);  fb.push_back(dp[7:0]);
        for (int i = 0; i < plen; i++) fb.push_back(8'(seed + 8'(i)));
    endtask

    task automatic send_frame(input logic fwd);
        for (int i = 0; i < fb.size(); i++) begin
            if (fwd && i >= 26) sb.push_back({(i == fb.size() - 1), fb[i]});
            send_beat(fb[i], i == fb.size() - 1);
        end
    endtask

    task automatic drain();
        s_valid = 1'b0;
        for (int t = 0; t < 300 && (sb.size() != 0 || m_valid); t++) @(negedge clk);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic logic accepts(input logic [47:0] dmac, input logic [15:0] et,
                                     input logic [31:0] dip, input logic [15:0] dp);
        logic addr_ok;
        addr_ok = ((dmac == LMAC) || (dmac == BCAST)) && (dip == LIP) && (dp == 16'd443);
        return (et == 16'h0800) && (!FILTER || addr_ok);
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_hv"},    64'(hv_cnt),       64'(exp_hv));
        chk({tag, "_drop"},  64'(drop_cnt),     64'(exp_drop));
        chk({tag, "_sport"}, 64'(hdr_src_port), 64'(exp_sport));
        chk({tag, "_sip"},   64'(hdr_ip_src),   64'(exp_sip));
        chk({tag, "_smac"},  64'(hdr_eth_src),  64'(exp_smac));
        chk({tag, "_sbq"},   64'(sb.size()),    64'(0));
    endtask

    task automatic run_frame(input string tag, input logic [47:0] dmac, input logic [15:0] et,
                             input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp,
                             input int plen, input logic [7:0] seed, input bit do_chk);
        logic acc;
        acc = accepts(dmac, et, dip, dp);
        build(dmac, et, SIP + 32'(sp), dip, sp, dp, plen, seed);
        send_frame(acc);
        if (acc) begin
            exp_hv++;
            exp_sport = sp;
            exp_sip   = SIP + 32'(sp);
            exp_smac  = SRC_MAC;
        end else begin
            exp_drop = exp_drop + 16'd1;
        end
        if (do_chk) begin
            drain();
            check_state(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready",  64'(s_ready),      64'(1'b0));
        chk("rst_m_valid",  64'(m_valid),      64'(1'b0));
        chk("rst_m_data",   64'(m_data),       64'(8'd0));
        chk("rst_hv",       64'(hdr_valid),    64'(1'b0));
        chk("rst_drop",     64'(drop_cnt),     64'(16'd0));
        chk("rst_sip",      64'(hdr_ip_src),   64'(32'd0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(s_ready), 64'(1'b1));

        // Good frame, payload "ABCD", src port 50000 / src IP C0A80001
        build(LMAC, 16'h0800, SIP, LIP, 16'd50000, 16'd443, 4, 8'h41);
        send_frame(1'b1);
        exp_hv = 1; exp_sport = 16'd50000; exp_sip = SIP; exp_smac = SRC_MAC;
        drain();
        check_state("good_abcd");

        // IPv6 ethertype is dropped with s_axis_tready held high
        stall_cnt = 0;
        run_frame("etype", LMAC, 16'h86DD, LIP, 16'd50001, 16'd443, 10, 8'h10, 1'b1);
        chk("etype_stalls", 64'(stall_cnt), 64'(0));
        chk("etype_ready",  64'(s_ready),   64'(1'b1));

        // Port 80: dropped only with address filtering
        run_frame("port80", LMAC, 16'h0800, LIP, 16'd50002, 16'd80, 6, 8'h20, 1'b1);

        // Broadcast destination MAC is accepted
        run_frame("bcast", BCAST, 16'h0800, LIP, 16'd1111, 16'd443, 3, 8'h30, 1'b1);

        // 100-byte payload under toggling downstream ready
        tog_en = 1'b1;
        run_frame("bp100", LMAC, 16'h0800, LIP, 16'd2222, 16'd443, 100, 8'h00, 1'b1);
        tog_en = 1'b0;

        // Runt: tlast on header byte 10, then a good frame
        build(LMAC, 16'h0800, SIP, LIP, 16'd9999, 16'd443, 0, 8'h00);
        while (fb.size() > 11) void'(fb.pop_back());
        send_frame(1'b0);
        exp_drop = exp_drop + 16'd1;
        drain();
        check_state("runt");
        run_frame("after_runt", LMAC, 16'h0800, LIP, 16'd3333, 16'd443, 5, 8'h50, 1'b1);

        // Zero-payload frame: header accepted, no m_axis beat
        run_frame("zero_pay", LMAC, 16'h0800, LIP, 16'd4444, 16'd443, 0, 8'h00, 1'b1);

        // Back-to-back frames with no idle cycles, a dropped one in between
        run_frame("b2b_a", LMAC, 16'h0800, LIP, 16'd5001, 16'd443, 2, 8'h60, 1'b0);
        run_frame("b2b_b", LMAC, 16'h0806, LIP, 16'd5002, 16'd443, 2, 8'h70, 1'b0);
        run_frame("b2b_c", LMAC, 16'h0800, LIP, 16'd5003, 16'd443, 3, 8'h80, 1'b0);
        drain();
        check_state("b2b");

        // Reset in the middle of a payload
        build(LMAC, 16'h0800, SIP, LIP, 16'd6000, 16'd443, 20, 8'h90);
        for (int i = 0; i < 34; i++) begin
            if (i >= 26) sb.push_back({1'b0, fb[i]});
            send_beat(fb[i], 1'b0);
        end
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_m_valid", 64'(m_valid),      64'(1'b0));
        chk("mid_rst_m_last",  64'(m_last),       64'(1'b0));
        chk("mid_rst_hv",      64'(hdr_valid),    64'(1'b0));
        chk("mid_rst_sport",   64'(hdr_src_port), 64'(16'd0));
        chk("mid_rst_drop",    64'(drop_cnt),     64'(16'd0));
        chk("mid_rst_ready",   64'(s_ready),      64'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_drop = 16'd0; exp_sport = 16'd0; exp_sip = 32'd0; exp_smac = 48'd0;
        exp_hv = hv_cnt;
        run_frame("after_rst", LMAC, 16'h0800, LIP, 16'd7000, 16'd443, 4, 8'hA0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
